register_read_stage: RTL



---
 rtl/mips_pkg.sv | 27 ++
 rtl/register_read_stage_if.sv | 26 ++
 rtl/register_read_stage_hazard_detect.sv | 17 +
 rtl/register_read_stage.sv | 115 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcodes, instruction field positions and decode helpers
package mips_pkg;
   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_ADDR_WIDTH = 5;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam int OP_HI = 31, OP_LO = 26;
   localparam int RS_HI = 25, RS_LO = 21;
   localparam int RT_HI = 20, RT_LO = 16;
   localparam int RD_HI = 15, RD_LO = 11;
   localparam int SH_HI = 10, SH_LO = 6;
   localparam int FN_HI = 5, FN_LO = 0;
   localparam int IMM_HI = 15, IMM_LO = 0;
   typedef enum logic {RUN, BUBBLE} state_t;
   function automatic logic zero_extends(input logic [5:0] op);
      return op inside {OP_ANDI, OP_ORI, OP_XORI};
   endfunction
   function automatic logic reads_rt(input logic [5:0] op);
      return op inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};
   endfunction
endpackage

// File: rtl/register_read_stage_if.sv
// register_read_stage_if: fetch handshake plus register-file read and write-back snoop ports
interface register_read_stage_if import mips_pkg::*; #(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
   logic                  instruction_valid;
   logic [31:0]           instruction;
   logic                  instruction_ready;
   logic [ADDR_WIDTH-1:0] read_register_1;
   logic [ADDR_WIDTH-1:0] read_register_2;
   logic [DATA_WIDTH-1:0] read_data_1;
   logic [DATA_WIDTH-1:0] read_data_2;
   logic                  register_write;
   logic [ADDR_WIDTH-1:0] write_register;
   logic [DATA_WIDTH-1:0] write_data;
   modport master (
      output instruction_valid, instruction, read_data_1, read_data_2,
             register_write, write_register, write_data,
      input  instruction_ready, read_register_1, read_register_2
   );
   modport slave (
      input  instruction_valid, instruction, read_data_1, read_data_2,
             register_write, write_register, write_data,
      output instruction_ready, read_register_1, read_register_2
   );
endinterface

// File: rtl/register_read_stage_hazard_detect.sv
// hazard_detect: load-use hazard between the instruction in ID and a load in EX
module hazard_detect import mips_pkg::*; #(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  valid,
   input  logic [5:0]            opcode,
   input  logic [ADDR_WIDTH-1:0] rs,
   input  logic [ADDR_WIDTH-1:0] rt,
   input  logic                  ex_mem_read,
   input  logic [ADDR_WIDTH-1:0] ex_write_register,
   output logic                  hazard
);
   logic uses_rt;
   assign uses_rt = reads_rt(opcode);
   assign hazard  = valid & ex_mem_read & (ex_write_register != '0) &
                    ((ex_write_register == rs) | (uses_rt & (ex_write_register == rt)));
endmodule

// File: rtl/register_read_stage.sv
// register_read_stage: owns IF/ID, reads the register file with write-back bypass, fills ID/EX
module register_read_stage import mips_pkg::*; #(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   register_read_stage_if.slave  bus,
   input  logic                  ex_mem_read,
   input  logic [ADDR_WIDTH-1:0] ex_write_register,
   input  logic                  ex_stall,
   input  logic                  flush,
   output logic                  id_ex_valid,
   output logic [DATA_WIDTH-1:0] id_ex_rs_data,
   output logic [DATA_WIDTH-1:0] id_ex_rt_data,
   output logic [ADDR_WIDTH-1:0] id_ex_rs,
   output logic [ADDR_WIDTH-1:0] id_ex_rt,
   output logic [ADDR_WIDTH-1:0] id_ex_rd,
   output logic [DATA_WIDTH-1:0] id_ex_immediate,
   output logic [5:0]            id_ex_opcode,
   output logic [5:0]            id_ex_funct,
   output logic [4:0]            id_ex_shamt,
   output logic                  load_use_stall,
   output logic [7:0]            stall_count
);
   state_t                state, state_next;
   logic                  if_id_valid;
   logic [31:0]           if_id_instruction;
   logic [5:0]            opcode;
   logic [ADDR_WIDTH-1:0] rs, rt, rd;
   logic [15:0]           imm16;
   logic [DATA_WIDTH-1:0] rs_data, rt_data, immediate;
   logic                  hazard, take;

   assign opcode = if_id_instruction[OP_HI:OP_LO];
   assign rs     = if_id_instruction[RS_HI:RS_LO];
   assign rt     = if_id_instruction[RT_HI:RT_LO];
   assign rd     = if_id_instruction[RD_HI:RD_LO];
   assign imm16  = if_id_instruction[IMM_HI:IMM_LO];
   assign bus.read_register_1 = rs;
   assign bus.read_register_2 = rt;
   assign rs_data = (rs == '0) ? '0 : (bus.register_write && bus.write_register == rs) ? bus.write_data : bus.read_data_1;
   assign rt_data = (rt == '0) ? '0 : (bus.register_write && bus.write_register == rt) ? bus.write_data : bus.read_data_2;
   assign immediate = zero_extends(opcode) ? {{(DATA_WIDTH-16){1'b0}}, imm16} : {{(DATA_WIDTH-16){imm16[15]}}, imm16};
   assign take = bus.instruction_ready & if_id_valid;

   hazard_detect #(.ADDR_WIDTH(ADDR_WIDTH)) u_hazard (
      .valid             (if_id_valid),
      .opcode            (opcode),
      .rs                (rs),
      .rt                (rt),
      .ex_mem_read       (ex_mem_read),
      .ex_write_register (ex_write_register),
      .hazard            (hazard)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= RUN;
      else state <= state_next;

   // next state and handshake: flush beats stall beats hazard; a hazard inserts one bubble
   always_comb begin
      state_next = state;
      bus.instruction_ready = 1'b0;
      load_use_stall = 1'b0;
      if (flush) state_next = RUN;
      else if (!ex_stall) begin
         state_next = hazard ? BUBBLE : RUN;
         bus.instruction_ready = reset_n & ~hazard;
         load_use_stall = reset_n & hazard;
      end
   end

   // IF/ID register and bubble counter
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         if_id_valid <= 1'b0;
         if_id_instruction <= '0;
         stall_count <= '0;
      end else begin
         if (flush) if_id_valid <= 1'b0;
         else if (bus.instruction_ready) begin
            if_id_valid <= bus.instruction_valid;
            if_id_instruction <= bus.instruction;
         end
         if (load_use_stall && stall_count != 8'hFF) stall_count <= stall_count + 8'd1;
      end

   // ID/EX register: decoded IF/ID on advance, zeroed bubble on hazard/flush/invalid, held on stall
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         id_ex_valid <= 1'b0;
         id_ex_rs_data <= '0;
         id_ex_rt_data <= '0;
         id_ex_rs <= '0;
         id_ex_rt <= '0;
         id_ex_rd <= '0;
         id_ex_immediate <= '0;
         id_ex_opcode <= '0;
         id_ex_funct <= '0;
         id_ex_shamt <= '0;
      end else if (flush || !ex_stall) begin
         id_ex_valid <= take;
         id_ex_rs_data <= take ? rs_data : '0;
         id_ex_rt_data <= take ? rt_data : '0;
         id_ex_rs <= take ? rs : '0;
         id_ex_rt <= take ? rt : '0;
         id_ex_rd <= take ? rd : '0;
         id_ex_immediate <= take ? immediate : '0;
         id_ex_opcode <= take ? opcode : '0;
         id_ex_funct <= take ? if_id_instruction[FN_HI:FN_LO] : '0;
         id_ex_shamt <= take ? if_id_instruction[SH_HI:SH_LO] : '0;
      end
endmodule
